sr_latch_writer: RTL and testbench

- Drives a bank of WIDTH gated SR latches through their S/R/En interface, acting as the write-side controller for latch storage.
- Accepts data words over a valid/ready handshake and converts each word to per-bit set/reset commands.
- Sequences a timed enable pulse (setup, pulse, hold) and never asserts S and R together on the same bit.
- Keeps a shadow copy of the stored value so that writes which change nothing are skipped.

---
 rtl/sr_latch_pkg.sv | 27 ++
 rtl/sr_phase_timer.sv | 27 ++
 rtl/sr_latch_writer.sv | 166 ++++++++++++++++
 tb/tb_sr_latch_writer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// Shared state encoding, phase counter width and phase length limits for the
// SR latch write controller (sr_latch_writer and sr_phase_timer).
package sr_latch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        CHECK
    } state_t;

    localparam int PHASE_W   = 4;
    localparam int PHASE_MIN = 1;
    localparam int PHASE_MAX = 15;

    // A phase of N cycles loads N-1; out-of-range lengths are clamped so the
    // counter can never wrap.
    function automatic logic [PHASE_W-1:0] phase_load(input int len);
        int clamped;
        clamped = len;
        if (clamped < PHASE_MIN) clamped = PHASE_MIN;
        if (clamped > PHASE_MAX) clamped = PHASE_MAX;
        return PHASE_W'(clamped - 1);
    endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter with a zero flag; times the SETUP, PULSE and HOLD
// phases of the latch write sequence.
module sr_phase_timer
    import sr_latch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_val,
    output logic               zero
);

    logic [PHASE_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sr_latch_writer.sv
// Write-side controller for a bank of gated SR latches: handshake in, per-bit
// S/R commands with a timed enable pulse out. Optional readback check is
// enabled by defining SR_LATCH_WRITER_VERIFY_EN.
module sr_latch_writer
    import sr_latch_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] latch_s,
    output logic [WIDTH-1:0] latch_r,
    output logic             latch_en,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             err
);

    state_t             state;
    state_t             state_next;
    logic               armed;
    logic [WIDTH-1:0]   shadow;
    logic               shadow_valid;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   chg;
    logic               accept;
    logic               redundant;
    logic               hold_exit;
    logic               write_done;
    logic               timer_load;
    logic [PHASE_W-1:0] timer_val;
    logic               timer_zero;

    // armed keeps wr_ready low until the first edge after reset releases.
    assign wr_ready  = armed && (state == IDLE);
    assign accept    = wr_valid && wr_ready;
    assign chg       = shadow_valid ? (wr_data ^ shadow) : '1;
    assign redundant = accept && (chg == '0);

    sr_phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        timer_val  = '0;
        hold_exit  = 1'b0;
        write_done = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !redundant) begin
                    state_next = SETUP;
                    timer_load = 1'b1;
                    timer_val  = phase_load(SETUP_CYC);
                end
            end
            SETUP: begin
                if (timer_zero) begin
                    state_next = PULSE;
                    timer_load = 1'b1;
                    timer_val  = phase_load(PULSE_CYC);
                end
            end
            PULSE: begin
                if (timer_zero) begin
                    state_next = HOLD;
                    timer_load = 1'b1;
                    timer_val  = phase_load(HOLD_CYC);
                end
            end
            HOLD: begin
                if (timer_zero) begin
                    hold_exit = 1'b1;
`ifdef SR_LATCH_WRITER_VERIFY_EN
                    state_next = CHECK;
`else
                    state_next = IDLE;
                    write_done = 1'b1;
`endif
                end
            end
            CHECK: begin
                state_next = IDLE;
`ifdef SR_LATCH_WRITER_VERIFY_EN
                write_done = 1'b1;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef SR_LATCH_WRITER_VERIFY_EN
    logic check_exit;
    logic mismatch;

    assign check_exit = (state == CHECK);
    assign mismatch   = (q_fb != shadow);
`else
    logic unused_q_fb;

    assign unused_q_fb = ^q_fb;
    assign err         = 1'b0;
`endif

    // latch_en is registered from the next state so the gate never glitches
    // on state decode; S/R are loaded on accept and dropped after HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed        <= 1'b0;
            latch_s      <= '0;
            latch_r      <= '0;
            latch_en     <= 1'b0;
            done         <= 1'b0;
            shadow       <= '0;
            shadow_valid <= 1'b0;
            data_q       <= '0;
`ifdef SR_LATCH_WRITER_VERIFY_EN
            err          <= 1'b0;
`endif
        end else begin
            armed    <= 1'b1;
            done     <= redundant || write_done;
            latch_en <= (state_next == PULSE);
            if (accept && !redundant) begin
                data_q  <= wr_data;
                latch_s <= wr_data & chg;
                latch_r <= ~wr_data & chg;
            end else if (hold_exit) begin
                latch_s <= '0;
                latch_r <= '0;
            end
            if (hold_exit) begin
                shadow       <= data_q;
                shadow_valid <= 1'b1;
            end
`ifdef SR_LATCH_WRITER_VERIFY_EN
            err <= check_exit && mismatch;
            if (check_exit && mismatch) begin
                shadow_valid <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sr_latch_writer.sv
// Directed self-checking bench for sr_latch_writer; the readback steps are
// included when SR_LATCH_WRITER_VERIFY_EN is defined.
module tb_sr_latch_writer;

`ifdef SR_LATCH_WRITER_VERIFY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       wr_valid   = 1'b0;
    logic [3:0] wr_data    = 4'b0000;
    logic [3:0] q_model    = 4'b0000;
    logic       force_zero = 1'b0;
    logic [3:0] q_fb;
    logic       wr_ready;
    logic       latch_en;
    logic       done;
    logic       err;
    logic [3:0] latch_s;
    logic [3:0] latch_r;
    int         checks   = 0;
    int         failures = 0;

    sr_latch_writer #(
        .WIDTH     (4),
        .SETUP_CYC (1),
        .PULSE_CYC (2),
        .HOLD_CYC  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .latch_s  (latch_s),
        .latch_r  (latch_r),
        .latch_en (latch_en),
        .q_fb     (q_fb),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Behavioural latch bank so the readback sees what the pulses wrote.
    always @(posedge clk) begin
        if (latch_en) q_model <= (q_model | latch_s) & ~latch_r;
    end
    assign q_fb = force_zero ? 4'b0000 : q_model;

    function automatic logic [31:0] outVec();
        return {20'b0, wr_ready, latch_en, done, err, latch_s, latch_r};
    endfunction

    function automatic logic [31:0] expVec(input logic rdy, input logic en, input logic dn,
                                           input logic er, input logic [3:0] s, input logic [3:0] r);
        return {20'b0, rdy, en, dn, er, s, r};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] data);
        wr_valid = valid;
        wr_data  = data;
    endtask

    task automatic idleCheck(input string tag);
        @(negedge clk);
        checkOutput(tag, outVec(), expVec(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
    endtask

    // Called at a negedge with the controller ready; returns at the negedge
    // of the done cycle. Output vector: {ready, en, done, err, s, r}.
    task automatic writeAndCheck(input string tag, input logic [3:0] data, input logic full,
                                 input logic [3:0] expS, input logic [3:0] expR, input logic expErr,
                                 input logic keepValid, input logic [3:0] nextData);
        checkOutput({tag, "_ready"}, {31'b0, wr_ready}, 32'd1);
        applyStimulus(1'b1, data);
        @(negedge clk);
        applyStimulus(keepValid, nextData);
        if (full) begin
            for (int c = 1; c <= 4 + EXTRA; c++) begin
                checkOutput($sformatf("%s_busy%0d", tag, c), outVec(),
                            expVec(1'b0, (c == 2 || c == 3), 1'b0, 1'b0,
                                   (c <= 4) ? expS : 4'b0000, (c <= 4) ? expR : 4'b0000));
                checkOutput($sformatf("%s_excl%0d", tag, c), {28'b0, latch_s & latch_r}, 32'd0);
                @(negedge clk);
            end
        end
        checkOutput({tag, "_done"}, outVec(), expVec(1'b1, 1'b0, 1'b1, expErr, 4'b0000, 4'b0000));
    endtask

    initial begin
        @(negedge clk);
        checkOutput("rst_outputs", outVec(), expVec(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
        @(negedge clk);
        checkOutput("rst_ready_held", outVec(), expVec(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", outVec(), expVec(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));

        writeAndCheck("first", 4'b1010, 1'b1, 4'b1010, 4'b0101, 1'b0, 1'b0, 4'b0000);
        idleCheck("first_done_clr");

        writeAndCheck("redund", 4'b1010, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111);
        idleCheck("redund_done_clr");

        writeAndCheck("bit0", 4'b1011, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000);
        idleCheck("bit0_done_clr");

        writeAndCheck("b2b_a", 4'b0011, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b1, 4'b1100);
        writeAndCheck("b2b_b", 4'b1100, 1'b1, 4'b1100, 4'b0011, 1'b0, 1'b0, 4'b0000);
        idleCheck("b2b_done_clr");

        applyStimulus(1'b1, 4'b0101);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("mid_setup", outVec(), expVec(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b1000));
        @(negedge clk);
        checkOutput("mid_pulse", outVec(), expVec(1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b1000));
        #2 rst = 1'b1;
        #1 checkOutput("async_rst", outVec(), expVec(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst2", outVec(), expVec(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));

        writeAndCheck("full_after_rst", 4'b0101, 1'b1, 4'b0101, 4'b1010, 1'b0, 1'b0, 4'b0000);
        idleCheck("full_after_rst_clr");
        writeAndCheck("redund2", 4'b0101, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);
        idleCheck("redund2_clr");

`ifdef SR_LATCH_WRITER_VERIFY_EN
        force_zero = 1'b1;
        writeAndCheck("verify_bad", 4'b0110, 1'b1, 4'b0010, 4'b0001, 1'b1, 1'b0, 4'b0000);
        force_zero = 1'b0;
        idleCheck("verify_err_clr");
        writeAndCheck("verify_full", 4'b0110, 1'b1, 4'b0110, 4'b1001, 1'b0, 1'b0, 4'b0000);
        idleCheck("verify_full_clr");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
